// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue path.
//   - ALU selector codes understood by the registered ALU (0x1..0xD)
//   - instruction opcode constants decoded by alu_issue_ctrl
//   - write-back entry and in-flight tag types
//   - immediate-extension helpers
package alu_pkg;

    // ALU selector codes; 0x0 makes the ALU return 0
    localparam logic [3:0] ALU_NOP   = 4'h0;
    localparam logic [3:0] ALU_ADD   = 4'h1;
    localparam logic [3:0] ALU_SUB   = 4'h2;
    localparam logic [3:0] ALU_SLL   = 4'h3;
    localparam logic [3:0] ALU_SRL   = 4'h4;
    localparam logic [3:0] ALU_SRA   = 4'h5;
    localparam logic [3:0] ALU_LTU   = 4'h6;
    localparam logic [3:0] ALU_LT    = 4'h7;
    localparam logic [3:0] ALU_NOR   = 4'h8;
    localparam logic [3:0] ALU_PASSA = 4'h9;
    localparam logic [3:0] ALU_AND   = 4'hA;
    localparam logic [3:0] ALU_OR    = 4'hB;
    localparam logic [3:0] ALU_XOR   = 4'hC;
    localparam logic [3:0] ALU_LUI   = 4'hD;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    // Branch flavour carried alongside an op until its zero flag is known
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_kind_t;

    // Write-back queue entry
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        branch_taken;
        logic        illegal;
    } wb_entry_t;

    // Per-op side information that travels with the ALU latency
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        br_kind_t   br;
        logic       illegal;
    } tag_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// alu_wb_fifo: synchronous FIFO with occupancy count.
// Parameters: DEPTH (power of 2, >= 2), WIDTH (entry width).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data   write an entry (caller guarantees no push when full
//                     unless a pop happens on the same edge)
//   pop          remove the head entry (caller guarantees not empty)
//   pop_data     head entry (undefined while empty)
//   empty        no entries
//   count        number of entries, 0..DEPTH
module alu_wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes instructions, issues operands to the registered
// ALU, follows the two-edge ALU latency and queues results for write-back.
// Optional build macro: PERF_CNT_EN (enables perf_issued / perf_stall).
// Ports:
//   clk, rst_n         clock shared with the ALU; async active-low reset
//   in_valid/in_ready  instruction handshake; instr, rs_data, rt_data operands
//   alu_sel/a/b        registered ALU controls
//   alu_result/zero    ALU outputs, one edge after alu_sel/a/b change
//   wb_*               head of the write-back queue, popped by wb_ready
//   perf_issued/stall  accept and stall counters (0 unless PERF_CNT_EN)
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [3:0]  alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic        wb_branch_taken,
    output logic        wb_illegal,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
);

    localparam int unsigned AW = $clog2(OUT_DEPTH);
    localparam int unsigned CW = AW + 2;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [15:0] imm16;
    logic [5:0]  funct;
    logic        unused_instr_bits;

    assign opcode = instr[31:26];
    assign f_rt   = instr[20:16];
    assign f_rd   = instr[15:11];
    assign imm16  = instr[15:0];
    assign funct  = instr[5:0];
    // Register values arrive pre-read, so rs and shamt fields are not needed
    assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

    // Decode
    logic [3:0]  dec_sel;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_rd;
    logic        dec_we;
    br_kind_t    dec_br;
    logic        dec_ill;

    always_comb begin
        dec_sel = ALU_NOP;
        dec_a   = '0;
        dec_b   = '0;
        dec_rd  = '0;
        dec_we  = 1'b0;
        dec_br  = BR_NONE;
        dec_ill = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct[5:4] == 2'b00 && funct[3:0] != 4'h0 && funct[3:0] <= ALU_LUI) begin
                    dec_sel = funct[3:0];
                    dec_a   = rs_data;
                    dec_b   = rt_data;
                    dec_rd  = f_rd;
                    dec_we  = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OP_ADDI: begin
                dec_sel = ALU_ADD;
                dec_a   = rs_data;
                dec_b   = sext16(imm16);
                dec_rd  = f_rt;
                dec_we  = 1'b1;
            end
            OP_SLTI: begin
                dec_sel = ALU_LT;
                dec_a   = rs_data;
                dec_b   = sext16(imm16);
                dec_rd  = f_rt;
                dec_we  = 1'b1;
            end
            OP_ANDI: begin
                dec_sel = ALU_AND;
                dec_a   = rs_data;
                dec_b   = zext16(imm16);
                dec_rd  = f_rt;
                dec_we  = 1'b1;
            end
            OP_ORI: begin
                dec_sel = ALU_OR;
                dec_a   = rs_data;
                dec_b   = zext16(imm16);
                dec_rd  = f_rt;
                dec_we  = 1'b1;
            end
            OP_XORI: begin
                dec_sel = ALU_XOR;
                dec_a   = rs_data;
                dec_b   = zext16(imm16);
                dec_rd  = f_rt;
                dec_we  = 1'b1;
            end
            OP_BEQ: begin
                dec_sel = ALU_SUB;
                dec_a   = rs_data;
                dec_b   = rt_data;
                dec_br  = BR_EQ;
            end
            OP_BNE: begin
                dec_sel = ALU_SUB;
                dec_a   = rs_data;
                dec_b   = rt_data;
                dec_br  = BR_NE;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Credit check: queued entries plus ops still inside the ALU latency
    // never exceed OUT_DEPTH, so a push always finds room.
    tag_t          tag_s1;
    tag_t          tag_s2;
    logic [AW:0]   fifo_count;
    logic [CW-1:0] credits_used;
    logic          accept;

    assign credits_used = CW'(fifo_count) + CW'(tag_s1.valid) + CW'(tag_s2.valid);
    assign in_ready     = credits_used < CW'(OUT_DEPTH);
    assign accept       = in_valid && in_ready;

    // Issue registers hold their value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (accept) begin
            alu_sel <= dec_sel;
            alu_a   <= dec_a;
            alu_b   <= dec_b;
        end
    end

    // Tag pipe: stage 1 lines up with the issue registers, stage 2 with the
    // ALU output register, so alu_result belongs to tag_s2 when it is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            tag_s1.valid   <= accept;
            tag_s1.rd      <= dec_rd;
            tag_s1.we      <= dec_we;
            tag_s1.br      <= dec_br;
            tag_s1.illegal <= dec_ill;
            tag_s2         <= tag_s1;
        end
    end

    // Write-back queue
    wb_entry_t push_entry;
    wb_entry_t head_entry;
    logic      fifo_empty;
    logic      pop;

    always_comb begin
        push_entry              = '0;
        push_entry.data         = alu_result;
        push_entry.rd           = tag_s2.rd;
        push_entry.we           = tag_s2.we;
        push_entry.illegal      = tag_s2.illegal;
        push_entry.branch_taken = ((tag_s2.br == BR_EQ) &&  alu_zero) ||
                                  ((tag_s2.br == BR_NE) && !alu_zero);
    end

    assign pop = wb_valid && wb_ready;

    alu_wb_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_wb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_s2.valid),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Fields read as zero whenever the queue is empty
    assign wb_valid        = !fifo_empty;
    assign wb_data         = wb_valid ? head_entry.data         : '0;
    assign wb_rd           = wb_valid ? head_entry.rd           : '0;
    assign wb_we           = wb_valid ? head_entry.we           : 1'b0;
    assign wb_branch_taken = wb_valid ? head_entry.branch_taken : 1'b0;
    assign wb_illegal      = wb_valid ? head_entry.illegal      : 1'b0;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept)               perf_issued <= perf_issued + 32'd1;
            if (in_valid && !in_ready) perf_stall  <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction-side initiator for the registered ALU. It decodes instructions, selects operands, and drives alu_sel, alu_a and alu_b. It tracks the two-edge ALU latency and captures alu_result and alu_zero into a write-back queue for the register-file and branch logic. It sits between the decode/register-read stage and write-back in the monocycle datapath.

Parameters:
OUT_DEPTH, 4, write-back FIFO depth (power of 2, at least 2); also the credit limit for accepted-but-unretired ops.

Ports:
clk  in  1  system clock; ALU shares this clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  instruction offered.
in_ready  out  1  block accepts the instruction this cycle.
instr  in  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm16, [5:0] funct.
rs_data  in  32  rs register value.
rt_data  in  32  rt register value.
alu_sel  out  4  ALU selector code.
alu_a  out  32  ALU operand A.
alu_b  out  32  ALU operand B.
alu_result  in  32  ALU result.
alu_zero  in  1  ALU zero flag.
wb_valid  out  1  head write-back entry is valid.
wb_ready  in  1  consumer pops the head entry.
wb_data  out  32  captured result.
wb_rd  out  5  destination register.
wb_we  out  1  register write required.
wb_branch_taken  out  1  branch resolved as taken.
wb_illegal  out  1  entry came from an illegal instruction.
perf_issued  out  32  count of accepted ops (PERF_CNT_EN only).
perf_stall  out  32  count of cycles with in_valid=1 and in_ready=0 (PERF_CNT_EN only).

Behaviour:
- Reset (async, rst_n=0): alu_sel=0, alu_a=0, alu_b=0, in-flight pipe cleared, FIFO emptied, wb_valid=0, all wb_* fields 0, perf counters 0. Ops in flight at reset are discarded.
- Decode of R-type (opcode 0x00):
  - alu_sel = funct[3:0] when funct[5:4]=0 and funct[3:0] is in 0x1..0xD; otherwise illegal.
  - A=rs_data, B=rt_data, dest=rd, we=1.
- Decode of I-type (dest=rt, we=1):
  - ADDI 0x08: ADD(0x1), B = sign-extended imm16.
  - SLTI 0x0A: LT(0x7), B = sign-extended imm16.
  - ANDI 0x0C: AND(0xA), B = zero-extended imm16.
  - ORI 0x0D: OR(0xB), B = zero-extended imm16.
  - XORI 0x0E: XOR(0xC), B = zero-extended imm16.
- Decode of branches: BEQ 0x04 and BNE 0x05 issue SUB(0x2) with A=rs_data, B=rt_data, we=0.
- Illegal instructions: issue alu_sel=0 (ALU returns 0), we=0, illegal=1. They still flow through the pipe in order.
- Accept rule: accept when in_valid && in_ready. in_ready = (fifo_count + inflight) < OUT_DEPTH, with inflight in 0..2. This rule alone guarantees the FIFO never overflows.
- Timing: accept at edge E0 registers alu_sel/a/b. The ALU computes at E1. The block pushes {alu_result, alu_zero, tag} into the FIFO at E2.
  - A FIFO entry is therefore visible at the earliest 2 edges after accept.
  - Throughput is 1 op per cycle.
- Idle: with no accept, alu_sel/a/b hold their last values; the tag-pipe valid bit is 0 so nothing is pushed.
- Branch resolution: wb_branch_taken = alu_zero for BEQ, !alu_zero for BNE, 0 otherwise. wb_data carries the SUB result.
- FIFO: pop on wb_valid && wb_ready. Simultaneous push and pop is allowed in any state, including full and empty. Pointers wrap modulo OUT_DEPTH.
- Ordering: strict in-order retirement.

Optional Feature:
PERF_CNT_EN
- Defined: perf_issued increments on every accept and perf_stall on every stalled cycle. Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: no counter logic is built and both ports are tied to 0.

Decomposition:
- Package alu_pkg holds:
  - ALU selector localparams 0x1..0xD.
  - Opcode constants 0x00, 0x04, 0x05, 0x08, 0x0A, 0x0C, 0x0D, 0x0E.
  - The packed wb-entry typedef {data, rd, we, branch_taken, illegal}.
- One sub-module: alu_wb_fifo, a synchronous FIFO with count output, parameterised on depth and width.

Test Plan:
- Reset mid-stream: accept 3 ADDs, assert rst_n=0 for 1 cycle. Required: wb_valid=0, in_ready=1, alu_sel=0, and no stale entries afterwards.
- R-type ADD: rs_data=5, rt_data=7, rd=3. Required: alu_sel=0x1 after E0, then wb_data=12, wb_rd=3, wb_we=1 two edges after accept.
- ADDI sign-extension: rs_data=10, imm16=0xFFFF. Required: alu_b=0xFFFFFFFF and wb_data=9. ORI with imm16=0x8000 → alu_b=0x00008000.
- Branches: BEQ with rs=rt=0x55 → wb_branch_taken=1, wb_we=0. BNE with rs=1, rt=2 → wb_branch_taken=1. BNE with equal operands → 0.
- Illegal and backpressure:
  - Opcode 0x3F → wb_illegal=1, wb_we=0, wb_data=0.
  - Hold wb_ready=0 and stream back-to-back ops: exactly OUT_DEPTH ops are accepted before in_ready=0. Release wb_ready and all 4 pop in order.
- PERF_CNT_EN build: 6 accepts plus 3 stalled cycles → perf_issued=6, perf_stall=3. Non-PERF build: both ports read 0.
